// File: rtl/spiflash_rd_ctrl.sv
// spiflash_rd_ctrl
//   SPI NOR flash read sequencer. After reset it sends a release-from-power-down
//   (0xAB), then serves 32-bit little-endian word fetches with READ (0x03) or,
//   when built with SPIFLASH_QUAD_EN, quad I/O READ (0xEB, mode byte 0x00).
//   SCK is mode 0; each SCK half-period lasts CLK_DIV clk cycles.
//
// Build option
//   SPIFLASH_QUAD_EN  defined: cfg_quad_i selects the 0xEB sequence.
//                     undefined: every fetch uses 0x03 and io3..io1 are never driven.
//
// Ports
//   clk_i          system clock
//   resetn_i       synchronous active-low reset
//   req_valid_i    fetch request; accepted when req_ready_o is also high
//   req_ready_o    high only while idle
//   req_addr_i     byte address of the first byte (captured at accept)
//   cfg_quad_i     quad read select (captured at accept)
//   rsp_valid_o    one-cycle pulse, rsp_data_o updated in the same cycle
//   rsp_data_o     {B[a+3],B[a+2],B[a+1],B[a]}, held until the next response
//   busy_o         high whenever the sequencer is not idle
//   flash_csb_o    chip select, active-low
//   flash_clk_o    SCK, idle low
//   flash_io_oe_o  per-pin output enable, io3..io0
//   flash_io_do_o  output data, io3..io0
//   flash_io_di_i  input data, io3..io0

module spiflash_rd_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_HIGH = 4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    input  logic        cfg_quad_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        flash_csb_o,
    output logic        flash_clk_o,
    output logic [3:0]  flash_io_oe_o,
    output logic [3:0]  flash_io_do_o,
    input  logic [3:0]  flash_io_di_i
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CSB_HIGH + 1) + 1;

    typedef enum logic [3:0] {
        S_WAKE,
        S_GAP,
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_TAIL
    } state_t;

    state_t             state_q, state_d;
    logic               csb_q, csb_d;
    logic               sck_q, sck_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         cnt_q, cnt_d;       // SCK periods left in current state
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               quad_q, quad_d;
    logic               fetch_q, fetch_d;   // 0 for the wake-up transfer
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [31:0]        sr_q, sr_d;         // outgoing bits, MSB on the wire next
    logic [31:0]        in_q, in_d;         // incoming bits, first byte ends up in [31:24]

    logic               last_div;
    logic               wide;
    logic               quad_sel;
    logic [3:0]         io_oe;

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

`ifdef SPIFLASH_QUAD_EN
    assign quad_sel = cfg_quad_i;
`else
    logic unused_cfg_quad;
    assign unused_cfg_quad = cfg_quad_i;
    assign quad_sel        = 1'b0;
`endif

    assign last_div = (div_q == DIV_W'(CLK_DIV - 1));
    // Address and mode nibbles of a quad read go out four bits per SCK.
    assign wide     = quad_q && ((state_q == S_ADDR) || (state_q == S_MODE));

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= S_WAKE;
            csb_q       <= 1'b1;
            sck_q       <= 1'b0;
            div_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            quad_q      <= 1'b0;
            fetch_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            sck_q       <= sck_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            quad_q      <= quad_d;
            fetch_q     <= fetch_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Shift registers carry no reset: sr_q is reloaded before csb falls and
    // in_q is fully refilled by every data phase.
    always_ff @(posedge clk_i) begin
        sr_q <= sr_d;
        in_q <= in_d;
    end

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        sck_d       = sck_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        quad_d      = quad_q;
        fetch_d     = fetch_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        sr_d        = sr_q;
        in_d        = in_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_CMD;
                    csb_d   = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    cnt_d   = 6'd8;
                    quad_d  = quad_sel;
                    fetch_d = 1'b1;
                    sr_d    = {(quad_sel ? 8'hEB : 8'h03), req_addr_i};
                end
            end

            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            S_TAIL: begin
                // Final SCK-low phase, then release csb and publish the word.
                if (last_div) begin
                    state_d     = S_GAP;
                    csb_d       = 1'b1;
                    div_d       = '0;
                    gap_d       = GAP_W'(CSB_HIGH);
                    rsp_valid_d = fetch_q;
                    if (fetch_q) begin
                        rsp_data_d = swap_bytes(in_q);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_WAKE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
                if ((state_q == S_WAKE) && csb_q) begin
                    // First cycle after reset: csb is still high, load 0xAB.
                    csb_d   = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    cnt_d   = 6'd8;
                    quad_d  = 1'b0;
                    fetch_d = 1'b0;
                    sr_d    = {8'hAB, 24'h000000};
                end else if (!last_div) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: capture the flash output.
                        sck_d = 1'b1;
                        if (state_q == S_DATA) begin
                            in_d = quad_q ? {in_q[27:0], flash_io_di_i}
                                          : {in_q[30:0], flash_io_di_i[1]};
                        end
                    end else begin
                        // Falling SCK: present the next bit(s).
                        sck_d = 1'b0;
                        sr_d  = wide ? (sr_q << 4) : (sr_q << 1);
                        if (cnt_q == 6'd1) begin
                            case (state_q)
                                S_CMD: begin
                                    state_d = S_ADDR;
                                    cnt_d   = quad_q ? 6'd6 : 6'd24;
                                end
                                S_ADDR: begin
                                    if (quad_q) begin
                                        state_d = S_MODE;
                                        cnt_d   = 6'd2;
                                    end else begin
                                        state_d = S_DATA;
                                        cnt_d   = 6'd32;
                                    end
                                end
                                S_MODE: begin
                                    state_d = S_DUMMY;
                                    cnt_d   = 6'd8;
                                end
                                S_DUMMY: begin
                                    state_d = S_DATA;
                                    cnt_d   = 6'd8;
                                end
                                default: begin
                                    state_d = S_TAIL;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_WAKE;
                csb_d   = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        io_oe = 4'b0000;
        if (!csb_q) begin
            case (state_q)
                S_WAKE, S_CMD:  io_oe = 4'b0001;
                S_ADDR, S_MODE: io_oe = quad_q ? 4'b1111 : 4'b0001;
                S_DATA, S_TAIL: io_oe = quad_q ? 4'b0000 : 4'b0001;
                default:        io_oe = 4'b0000;
            endcase
        end
    end

    assign flash_io_oe_o = io_oe;
    assign flash_io_do_o = io_oe & (wide ? sr_q[31:28] : {3'b000, sr_q[31]});
    assign flash_csb_o   = csb_q;
    assign flash_clk_o   = sck_q;
    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;

endmodule
